// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, default bubble encoding, PC increment.
package pipeline_pkg;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } fetch_state_t;

   localparam logic [0:31] NOP_INSTR_DEFAULT = 32'h5400_0000;
   localparam logic [0:31] PC_INC            = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble overrides load; neither asserted means hold.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [0:31] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        bubble,
   input  logic [0:31] instr_in,
   input  logic [0:31] pc_plus_4_in,
   output logic [0:31] instruction,
   output logic [0:31] pc_plus_4,
   output logic        valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instruction <= NOP_INSTR;
         pc_plus_4   <= '0;
         valid       <= 1'b0;
      end else if (bubble) begin
         instruction <= NOP_INSTR;
         valid       <= 1'b0;
      end else if (load) begin
         instruction <= instr_in;
         pc_plus_4   <= pc_plus_4_in;
         valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/rdy sequencing, skid buffer and IF/ID register.
// Define IF_DELAY_SLOT_EN to keep the sequential instruction after a taken redirect.
module if_stage
   import pipeline_pkg::*;
#(
   parameter logic [0:31] RESET_PC  = 32'h0000_0000,
   parameter logic [0:31] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall_ID,
   input  logic        REDIRECT,
   input  logic [0:31] REDIRECT_PC,
   output logic        IMEM_REQ,
   output logic [0:31] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic [0:31] IMEM_DATA,
   output logic [0:31] instruction,
   output logic [0:31] PC_PLUS_4,
   output logic        IF_VALID
);

`ifdef IF_DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   fetch_state_t state_q;
   logic [0:31]  pc_q;
   logic [0:31]  addr_q;
   logic         req_q;
   logic [0:31]  skid_instr_q;
   logic [0:31]  skid_pc4_q;
   logic [0:31]  pc_plus_4;
   logic         honour;
   logic         jump;
   logic [0:31]  jump_pc;
   logic         idr_load;
   logic         idr_bubble;
   logic [0:31]  idr_instr;
   logic [0:31]  idr_pc4;

   assign pc_plus_4 = pc_q + PC_INC;
   assign honour    = REDIRECT & ~Stall_ID;
   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = addr_q;

`ifdef IF_DELAY_SLOT_EN
   logic        pend_q;
   logic [0:31] pend_pc_q;

   // Jump applies once the delay-slot fetch completes; a newer redirect wins.
   assign jump    = honour | pend_q;
   assign jump_pc = honour ? REDIRECT_PC : pend_pc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else if (state_q == S_REQ) begin
         if (IMEM_RDY) begin
            pend_q <= 1'b0;
         end else if (honour) begin
            pend_q    <= 1'b1;
            pend_pc_q <= REDIRECT_PC;
         end
      end
   end
`else
   assign jump    = honour;
   assign jump_pc = REDIRECT_PC;
`endif

   // addr_q tracks pc_q except in S_DROP, where the abandoned address must stay on the bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_RESET;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc4_q   <= '0;
      end else begin
         unique case (state_q)
            S_RESET: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
               addr_q  <= pc_q;
            end
            S_REQ: begin
               if (IMEM_RDY) begin
                  pc_q   <= jump ? jump_pc : pc_plus_4;
                  addr_q <= jump ? jump_pc : pc_plus_4;
                  if (Stall_ID) begin
                     skid_instr_q <= IMEM_DATA;
                     skid_pc4_q   <= pc_plus_4;
                     state_q      <= S_HOLD;
                     req_q        <= 1'b0;
                  end
               end else if (honour && !DELAY_SLOT) begin
                  pc_q    <= REDIRECT_PC;
                  state_q <= S_DROP;
               end
            end
            S_HOLD: begin
               if (!Stall_ID) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
                  if (REDIRECT) begin
                     pc_q   <= REDIRECT_PC;
                     addr_q <= REDIRECT_PC;
                  end
               end
            end
            S_DROP: begin
               if (honour) pc_q <= REDIRECT_PC;
               if (IMEM_RDY) begin
                  state_q <= S_REQ;
                  addr_q  <= honour ? REDIRECT_PC : pc_q;
               end
            end
            default: state_q <= S_RESET;
         endcase
      end
   end

   always_comb begin
      idr_load   = 1'b0;
      idr_bubble = 1'b0;
      idr_instr  = IMEM_DATA;
      idr_pc4    = pc_plus_4;
      if (!Stall_ID) begin
         case (state_q)
            S_REQ: begin
               if (IMEM_RDY && (DELAY_SLOT || !REDIRECT)) idr_load = 1'b1;
               else idr_bubble = 1'b1;
            end
            S_HOLD: begin
               idr_instr = skid_instr_q;
               idr_pc4   = skid_pc4_q;
               if (REDIRECT && !DELAY_SLOT) idr_bubble = 1'b1;
               else idr_load = 1'b1;
            end
            S_DROP:  idr_bubble = 1'b1;
            default: ;
         endcase
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk          (clk),
      .reset        (reset),
      .load         (idr_load),
      .bubble       (idr_bubble),
      .instr_in     (idr_instr),
      .pc_plus_4_in (idr_pc4),
      .instruction  (instruction),
      .pc_plus_4    (PC_PLUS_4),
      .valid        (IF_VALID)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency instruction memory model.
module tb_if_stage;

   localparam logic [0:31] NOP = 32'h5400_0000;

   logic        clk;
   logic        reset;
   logic        Stall_ID;
   logic        REDIRECT;
   logic [0:31] REDIRECT_PC;
   logic        IMEM_REQ;
   logic [0:31] IMEM_ADDR;
   logic        IMEM_RDY;
   logic [0:31] IMEM_DATA;
   logic [0:31] instruction;
   logic [0:31] PC_PLUS_4;
   logic        IF_VALID;

   int          checks;
   int          passed;
   int unsigned mem_lat;
   bit          mem_block;
   int unsigned wait_cnt;

   if_stage u_dut (
      .clk         (clk),
      .reset       (reset),
      .Stall_ID    (Stall_ID),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_RDY    (IMEM_RDY),
      .IMEM_DATA   (IMEM_DATA),
      .instruction (instruction),
      .PC_PLUS_4   (PC_PLUS_4),
      .IF_VALID    (IF_VALID)
   );

   function automatic logic [0:31] word_of(input logic [0:31] a);
      return a ^ 32'h5A5A_0001;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory completes after mem_lat extra cycles; mem_block forces it to stall.
   always @(posedge clk or negedge reset) begin
      if (!reset) wait_cnt <= 0;
      else if (!IMEM_REQ || IMEM_RDY) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end
   assign IMEM_RDY  = IMEM_REQ && !mem_block && (wait_cnt >= mem_lat);
   assign IMEM_DATA = word_of(IMEM_ADDR);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "timeout");
   end

   // Returns at a falling edge with reset just released; next rising edge leaves S_RESET.
   task automatic apply_reset(input int unsigned lat);
      reset     = 1'b0;
      Stall_ID  = 1'b0;
      REDIRECT  = 1'b0;
      REDIRECT_PC = '0;
      mem_block = 1'b0;
      mem_lat   = lat;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; Stall_ID = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
      mem_block = 1'b0; mem_lat = 0;
      repeat (2) @(negedge clk);
      checks++; if (IMEM_REQ !== 1'b0) $display("FAIL rst_req: got %b want 0", IMEM_REQ); else passed++;
      checks++; if (instruction !== NOP) $display("FAIL rst_instr: got %h want %h", instruction, NOP); else passed++;
      checks++; if (PC_PLUS_4 !== 32'h0) $display("FAIL rst_pc4: got %h want 0", PC_PLUS_4); else passed++;
      checks++; if (IF_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", IF_VALID); else passed++;
   endtask

   task automatic test_reset_midrun();
      apply_reset(1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++; if (IF_VALID !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", IF_VALID); else passed++;
      #2 reset = 1'b0;
      #1;
      checks++; if (IMEM_REQ !== 1'b0) $display("FAIL mid_req: got %b want 0", IMEM_REQ); else passed++;
      checks++; if (IF_VALID !== 1'b0) $display("FAIL mid_valid: got %b want 0", IF_VALID); else passed++;
      checks++; if (instruction !== NOP) $display("FAIL mid_instr: got %h want %h", instruction, NOP); else passed++;
   endtask

   task automatic test_zero_wait();
      apply_reset(0);
      @(negedge clk);
      checks++; if (IMEM_ADDR !== 32'h0 || IMEM_REQ !== 1'b1)
         $display("FAIL zw_first: got addr %h req %b want 0 1", IMEM_ADDR, IMEM_REQ); else passed++;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++; if (IMEM_ADDR !== 32'(4 * k)) $display("FAIL zw_addr%0d: got %h want %h", k, IMEM_ADDR, 32'(4 * k)); else passed++;
         checks++; if (instruction !== word_of(32'(4 * (k - 1))))
            $display("FAIL zw_instr%0d: got %h want %h", k, instruction, word_of(32'(4 * (k - 1)))); else passed++;
         checks++; if (PC_PLUS_4 !== 32'(4 * k)) $display("FAIL zw_pc4_%0d: got %h want %h", k, PC_PLUS_4, 32'(4 * k)); else passed++;
         checks++; if (IF_VALID !== 1'b1) $display("FAIL zw_valid%0d: got %b want 1", k, IF_VALID); else passed++;
      end
   endtask

   task automatic test_latency2();
      apply_reset(1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (IMEM_ADDR !== 32'(4 * k)) $display("FAIL l2_hold_addr%0d: got %h want %h", k, IMEM_ADDR, 32'(4 * k)); else passed++;
         checks++; if (IF_VALID !== 1'b0 || instruction !== NOP)
            $display("FAIL l2_bubble%0d: got %b %h want 0 %h", k, IF_VALID, instruction, NOP); else passed++;
         @(negedge clk);
         checks++; if (IMEM_ADDR !== 32'(4 * (k + 1))) $display("FAIL l2_addr%0d: got %h want %h", k, IMEM_ADDR, 32'(4 * (k + 1))); else passed++;
         checks++; if (IF_VALID !== 1'b1 || instruction !== word_of(32'(4 * k)))
            $display("FAIL l2_instr%0d: got %b %h want 1 %h", k, IF_VALID, instruction, word_of(32'(4 * k))); else passed++;
      end
   endtask

   task automatic test_stall();
      apply_reset(0);
      repeat (3) @(negedge clk);
      Stall_ID = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (IMEM_REQ !== 1'b0) $display("FAIL st_req%0d: got %b want 0", k, IMEM_REQ); else passed++;
         checks++; if (instruction !== word_of(32'h4) || IF_VALID !== 1'b1)
            $display("FAIL st_hold%0d: got %h %b want %h 1", k, instruction, IF_VALID, word_of(32'h4)); else passed++;
      end
      Stall_ID = 1'b0;
      @(negedge clk);
      checks++; if (instruction !== word_of(32'h8)) $display("FAIL st_skid: got %h want %h", instruction, word_of(32'h8)); else passed++;
      checks++; if (PC_PLUS_4 !== 32'hC) $display("FAIL st_pc4: got %h want 0000000c", PC_PLUS_4); else passed++;
      checks++; if (IMEM_ADDR !== 32'hC || IMEM_REQ !== 1'b1)
         $display("FAIL st_next: got addr %h req %b want 0000000c 1", IMEM_ADDR, IMEM_REQ); else passed++;
   endtask

   task automatic test_redirect_drop();
      apply_reset(0);
      repeat (5) @(negedge clk);
      mem_block = 1'b1;
      @(negedge clk);
      checks++; if (IMEM_ADDR !== 32'h10 || IF_VALID !== 1'b0)
         $display("FAIL rd_wait: got addr %h valid %b want 00000010 0", IMEM_ADDR, IF_VALID); else passed++;
      REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
      @(negedge clk);
      REDIRECT = 1'b0;
      mem_block = 1'b0;
`ifdef IF_DELAY_SLOT_EN
      checks++; if (IMEM_ADDR !== 32'h10 || IMEM_REQ !== 1'b1)
         $display("FAIL rd_pend_addr: got %h req %b want 00000010 1", IMEM_ADDR, IMEM_REQ); else passed++;
      @(negedge clk);
      checks++; if (instruction !== word_of(32'h10) || IF_VALID !== 1'b1)
         $display("FAIL rd_slot: got %h %b want %h 1", instruction, IF_VALID, word_of(32'h10)); else passed++;
`else
      checks++; if (IMEM_ADDR !== 32'h10 || IMEM_REQ !== 1'b1)
         $display("FAIL rd_drop_addr: got %h req %b want 00000010 1", IMEM_ADDR, IMEM_REQ); else passed++;
      @(negedge clk);
      checks++; if (instruction !== NOP || IF_VALID !== 1'b0)
         $display("FAIL rd_discard: got %h %b want %h 0", instruction, IF_VALID, NOP); else passed++;
`endif
      checks++; if (IMEM_ADDR !== 32'h100) $display("FAIL rd_target: got %h want 00000100", IMEM_ADDR); else passed++;
      @(negedge clk);
      checks++; if (instruction !== word_of(32'h100) || PC_PLUS_4 !== 32'h104)
         $display("FAIL rd_first: got %h %h want %h 00000104", instruction, PC_PLUS_4, word_of(32'h100)); else passed++;
   endtask

   task automatic test_redirect_stall();
      apply_reset(0);
      repeat (2) @(negedge clk);
      Stall_ID = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
      @(negedge clk);
      checks++; if (IMEM_REQ !== 1'b0 || instruction !== word_of(32'h0))
         $display("FAIL rs_ignored: got req %b instr %h want 0 %h", IMEM_REQ, instruction, word_of(32'h0)); else passed++;
      REDIRECT_PC = 32'h200;
      @(negedge clk);
      Stall_ID = 1'b0;
      @(negedge clk);
      REDIRECT = 1'b0;
      checks++; if (IMEM_ADDR !== 32'h200 || IMEM_REQ !== 1'b1)
         $display("FAIL rs_target: got %h req %b want 00000200 1", IMEM_ADDR, IMEM_REQ); else passed++;
`ifdef IF_DELAY_SLOT_EN
      checks++; if (instruction !== word_of(32'h4) || IF_VALID !== 1'b1)
         $display("FAIL rs_slot: got %h %b want %h 1", instruction, IF_VALID, word_of(32'h4)); else passed++;
`else
      checks++; if (instruction !== NOP || IF_VALID !== 1'b0)
         $display("FAIL rs_flush: got %h %b want %h 0", instruction, IF_VALID, NOP); else passed++;
`endif
      @(negedge clk);
      checks++; if (instruction !== word_of(32'h200) || PC_PLUS_4 !== 32'h204)
         $display("FAIL rs_first: got %h %h want %h 00000204", instruction, PC_PLUS_4, word_of(32'h200)); else passed++;
   endtask

   task automatic test_branch_slot();
      apply_reset(0);
      repeat (10) @(negedge clk);
      checks++; if (instruction !== word_of(32'h20) || IMEM_ADDR !== 32'h24)
         $display("FAIL br_setup: got %h addr %h want %h 00000024", instruction, IMEM_ADDR, word_of(32'h20)); else passed++;
      REDIRECT = 1'b1; REDIRECT_PC = 32'h80;
      @(negedge clk);
      REDIRECT = 1'b0;
`ifdef IF_DELAY_SLOT_EN
      checks++; if (instruction !== word_of(32'h24) || IF_VALID !== 1'b1 || PC_PLUS_4 !== 32'h28)
         $display("FAIL br_slot: got %h %b %h want %h 1 00000028", instruction, IF_VALID, PC_PLUS_4, word_of(32'h24)); else passed++;
`else
      checks++; if (instruction !== NOP || IF_VALID !== 1'b0)
         $display("FAIL br_flush: got %h %b want %h 0", instruction, IF_VALID, NOP); else passed++;
`endif
      checks++; if (IMEM_ADDR !== 32'h80) $display("FAIL br_target: got %h want 00000080", IMEM_ADDR); else passed++;
   endtask

   task automatic test_wrap();
      apply_reset(0);
      @(negedge clk);
      REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
      @(negedge clk);
      REDIRECT = 1'b0;
      checks++; if (IMEM_ADDR !== 32'hFFFF_FFFC) $display("FAIL wr_addr: got %h want fffffffc", IMEM_ADDR); else passed++;
      @(negedge clk);
      checks++; if (PC_PLUS_4 !== 32'h0) $display("FAIL wr_pc4: got %h want 00000000", PC_PLUS_4); else passed++;
      checks++; if (IMEM_ADDR !== 32'h0) $display("FAIL wr_next: got %h want 00000000", IMEM_ADDR); else passed++;
      checks++; if (instruction !== word_of(32'hFFFF_FFFC))
         $display("FAIL wr_instr: got %h want %h", instruction, word_of(32'hFFFF_FFFC)); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_reset_midrun();
      test_zero_wait();
      test_latency2();
      test_stall();
      test_redirect_drop();
      test_redirect_stall();
      test_branch_slot();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
